// File: rtl/jt1942_objscan.sv
// rtl/jt1942_objscan.sv - object line-scan into a double-buffered per-line object list
// Optional JT1942_OBJSCAN_LIMIT_EN: caps accepted objects per line at MAXOBJ and raises ovf.
module jt1942_objscan #(
    parameter int MAXOBJ = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen6,
    input  logic [7:0]  V,
    input  logic        HINIT,
    input  logic [3:0]  pxlcnt,
    input  logic [4:0]  objcnt,
    input  logic        line,
    input  logic        SEATM_b,
    output logic [6:0]  ram_addr,
    input  logic [7:0]  ram_dout,
    input  logic [4:0]  rd_obj,
    output logic [31:0] rd_data,
    output logic [5:0]  obj_num,
    output logic        ovf
);
    typedef enum logic [2:0] {IDLE, FY, FA, CHK, CPY} state_t;
    state_t state, state_nxt;

    logic [4:0]  obj_r;
    logic [7:0]  y_r, attr_r, code_r, vrel_r;
    logic [5:0]  count;
    logic [31:0] mem [0:63];

    logic [7:0] vrel;
    logic [7:0] height;
    logic       start, match, full, limit_hit, accept;

    assign vrel   = V - y_r;
    assign start  = (state == IDLE) && (pxlcnt == 4'd0) && !SEATM_b;
    assign match  = vrel < height;
    assign full   = count == 6'd32;
    assign accept = (state == CPY) && !full && !limit_hit;

    always_comb begin
        case (attr_r[7:6])
            2'b01:   height = 8'd32;
            2'b10:   height = 8'd64;
            default: height = 8'd16;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FY;
            FY:      state_nxt = FA;
            FA:      state_nxt = CHK;
            CHK:     state_nxt = match ? CPY : IDLE;
            CPY:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (HINIT) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else if (cen6) state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr <= '0;
            obj_r    <= '0;
            y_r      <= '0;
            attr_r   <= '0;
            code_r   <= '0;
            vrel_r   <= '0;
            count    <= '0;
            obj_num  <= '0;
        end else if (cen6) begin
            if (HINIT) begin
                obj_num <= count;
                count   <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        obj_r    <= objcnt;
                        ram_addr <= {objcnt, 2'd2};
                    end
                    FY: begin
                        y_r      <= ram_dout;
                        ram_addr <= {obj_r, 2'd1};
                    end
                    FA: begin
                        attr_r   <= ram_dout;
                        ram_addr <= {obj_r, 2'd0};
                    end
                    CHK: begin
                        code_r   <= ram_dout;
                        vrel_r   <= vrel;
                        ram_addr <= {obj_r, 2'd3};
                    end
                    default: ;
                endcase
                if (accept) count <= count + 6'd1;
            end
        end
    end

    // ram_dout carries X during CPY, so it goes straight into the entry
    always_ff @(posedge clk) begin
        if (cen6 && !rst && !HINIT && accept)
            mem[{line, count[4:0]}] <= {code_r, attr_r, vrel_r, ram_dout};
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else rd_data <= mem[{~line, rd_obj}];
    end

`ifdef JT1942_OBJSCAN_LIMIT_EN
    localparam logic [5:0] MAX_CNT = 6'(MAXOBJ);

    assign limit_hit = count >= MAX_CNT;

    always_ff @(posedge clk) begin
        if (rst) ovf <= 1'b0;
        else if (cen6) begin
            if (HINIT) ovf <= 1'b0;
            else if (state == CPY && limit_hit) ovf <= 1'b1;
        end
    end
`else
    logic unused_maxobj;
    assign unused_maxobj = MAXOBJ != 0;
    assign limit_hit     = 1'b0;
    assign ovf           = 1'b0;
`endif
endmodule

// File: doc/jt1942_objscan.md
Name: jt1942_objscan

Overview:
- Object line-scan stage that sits directly downstream of the object timing generator.
- Consumes the object scan sequence (objcnt, pxlcnt), the line-parity bit and the SEATM_b scan window.
- During the window it reads every object's 4-byte record from object RAM and tests it against the current line V.
- Matching objects are copied into one bank of a double-buffered per-line object list. The pixel-drawing stage reads the other bank.

Parameters:
MAXOBJ, 16, maximum objects accepted per line (only used with JT1942_OBJSCAN_LIMIT_EN).

Ports:
clk        in   1   system clock
rst        in   1   reset, synchronous, active-high
cen6       in   1   6 MHz clock enable; all state advances only on clk edges with cen6=1
V          in   8   current scan line
HINIT      in   1   line start, sampled with cen6
pxlcnt     in   4   pixel counter within object slot
objcnt     in   5   object index being scanned
line       in   1   line parity; selects the write bank
SEATM_b    in   1   active-low object scan window
ram_addr   out  7   object RAM address {object, byte}, registered
ram_dout   in   8   object RAM data, valid one cen6 tick after ram_addr
rd_obj     in   5   draw-side entry index
rd_data    out  32  draw-side entry {code, attr, vrel, x}, registered, 1 clk latency
obj_num    out  6   number of valid entries in the draw bank (0..32)
ovf        out  1   line overflow flag

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ram_addr=0; wr count=0; obj_num=0; ovf=0; rd_data=0. Buffer contents are undefined after reset.
- Banks: the write bank is `line`; the read bank is `~line`. Storage is 64 x 32 bits, addressed as {bank, index}.
- Record layout in object RAM: byte0=code, byte1=attr, byte2=Y, byte3=X.
- Object height is set by attr[7:6]: 00 gives 16, 01 gives 32, 10 gives 64, 11 gives 16.
- Match rule: vrel = V - Y (8-bit, wraps modulo 256). An object matches when vrel < height.
- FSM, one step per cen6 tick:
  - IDLE: if pxlcnt==0 and SEATM_b==0, latch objcnt into obj_r, ram_addr<={obj_r,2}, go to FY. Otherwise stay in IDLE.
  - FY: Y<=ram_dout; ram_addr<={obj_r,1}; go to FA.
  - FA: attr<=ram_dout; ram_addr<={obj_r,0}; go to CHK.
  - CHK: code<=ram_dout; ram_addr<={obj_r,3}. If match, go to CPY; otherwise go to IDLE.
  - CPY: write {code, attr, vrel, ram_dout} to entry {line, count}; count<=count+1; go to IDLE.
- Each slot takes 5 ticks, well inside the 16-tick object slot.
- HINIT tick:
  - obj_num<=count; if count already equals 32, obj_num=32.
  - count<=0; ovf<=0; FSM forced to IDLE.
  - HINIT wins over a simultaneous CPY; that write is dropped.
- SEATM_b rising mid-object: the object in flight completes; no new slot starts.
- count saturates at 32 and never wraps.
- rd_data<=mem[{~line, rd_obj}] on every clk, regardless of cen6.

Optional Feature:
JT1942_OBJSCAN_LIMIT_EN
- Defined: once count==MAXOBJ, further matches are discarded with no write and no increment, and ovf<=1 until the next HINIT.
- Undefined: all 32 objects can be accepted, ovf is tied to 0, and MAXOBJ is ignored.

Test Plan:
- Reset check: rst high for 3 ticks -> obj_num=0, ovf=0, ram_addr=0, FSM IDLE; no ram_addr change while SEATM_b=1.
- Single match: obj 5 = {code 0x12, attr 0x00, Y 0x40, X 0x80}, V=0x48, line=0 -> bank0 entry0 = 0x12000880; after HINIT with line=1, rd_obj=0 gives 0x12000880 and obj_num=1.
- Height and wrap: attr 0x40, Y=0xF0, V=0x0A (vrel=0x1A) -> match. Same object with attr 0x00 -> no match. V=0xEF -> no match.
- Full table: all 32 objects match, macro undefined -> obj_num=32, entries in objcnt scan order, ovf=0. Macro defined with MAXOBJ=16 -> obj_num=16, ovf=1.
- Abort cases: HINIT coincident with CPY -> entry not written and count=0. rst asserted mid-CPY -> IDLE, obj_num=0.
